// File: rtl/fpga_io_router.sv
// rtl/fpga_io_router.sv - Wishbone-programmable pad router between Caravel user IO and FPGA fabric GPIO
module fpga_io_router #(
    parameter int          NUM_PADS    = 38,
    parameter int          NUM_FPGA_IO = 38,
    parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic [NUM_PADS-1:0]    io_in,
    output logic [NUM_PADS-1:0]    io_out,
    output logic [NUM_PADS-1:0]    io_oeb,
    input  logic [NUM_FPGA_IO-1:0] fpga_out,
    output logic [NUM_FPGA_IO-1:0] fpga_in
);
    localparam logic [7:0] VERSION  = 8'h02;
    localparam logic [9:0] W_CTRL   = 10'h000;
    localparam logic [9:0] W_INFO   = 10'h001;
    localparam logic [9:0] W_OUT_LO = 10'h004;
    localparam logic [9:0] W_OUT_HI = 10'h005;
    localparam logic [9:0] W_IN_LO  = 10'h006;
    localparam logic [9:0] W_IN_HI  = 10'h007;
    localparam logic [9:0] W_PADCFG = 10'h040;

    logic                   ack_q;
    logic [31:0]            dat_q;
    logic                   route_en_q, route_en_d;
    logic [NUM_PADS-1:0]    wb_out_q, wb_out_d;
    logic [5:0]             cfg_idx_q [NUM_PADS];
    logic [5:0]             cfg_idx_d [NUM_PADS];
    logic [NUM_PADS-1:0]    cfg_en_q, cfg_en_d;
    logic [NUM_PADS-1:0]    cfg_dir_q, cfg_dir_d;
    logic [NUM_PADS-1:0]    cfg_src_q, cfg_src_d;
    logic [NUM_PADS-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0]    io_out_q, io_out_d;
    logic [NUM_PADS-1:0]    io_oeb_q, io_oeb_d;
    logic [NUM_FPGA_IO-1:0] fpga_in_q, fpga_in_d;

    logic                   window_hit, req, wr, rd;
    logic [9:0]             word;
    logic [31:0]            rdata;
    logic [NUM_PADS-1:0]    sync_in, active;
    logic [63:0]            wb_out_ext, pad_in_ext, fpga_out_ext;
    logic [1:0]             unused_adr_lsb;

    // ~ack_q spaces requests so every access takes exactly two cycles
    assign window_hit     = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign req            = wbs_stb_i & wbs_cyc_i & window_hit & ~ack_q;
    assign wr             = req & wbs_we_i;
    assign rd             = req & ~wbs_we_i;
    assign word           = wbs_adr_i[11:2];
    assign unused_adr_lsb = wbs_adr_i[1:0];
    assign sync_in        = sync_q[SYNC_STAGES-1];

    always_comb begin
        wb_out_ext                   = '0;
        wb_out_ext[NUM_PADS-1:0]     = wb_out_q;
        pad_in_ext                   = '0;
        pad_in_ext[NUM_PADS-1:0]     = sync_in;
        fpga_out_ext                 = '0;
        fpga_out_ext[NUM_FPGA_IO-1:0] = fpga_out;
    end

    always_comb begin
        rdata = '0;
        case (word)
            W_CTRL:   rdata[0] = route_en_q;
            W_INFO:   rdata = {VERSION, 8'(SYNC_STAGES), 8'(NUM_FPGA_IO), 8'(NUM_PADS)};
            W_OUT_LO: rdata = wb_out_ext[31:0];
            W_OUT_HI: rdata = wb_out_ext[63:32];
            W_IN_LO:  rdata = pad_in_ext[31:0];
            W_IN_HI:  rdata = pad_in_ext[63:32];
            default: begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    if (word == W_PADCFG + 10'(p)) begin
                        rdata = {22'b0, cfg_src_q[p], cfg_dir_q[p], cfg_en_q[p], 1'b0, cfg_idx_q[p]};
                    end
                end
            end
        endcase
    end

    always_comb begin
        route_en_d = route_en_q;
        wb_out_d   = wb_out_q;
        cfg_idx_d  = cfg_idx_q;
        cfg_en_d   = cfg_en_q;
        cfg_dir_d  = cfg_dir_q;
        cfg_src_d  = cfg_src_q;
        if (wr) begin
            if (word == W_CTRL && wbs_sel_i[0]) begin
                route_en_d = wbs_dat_i[0];
            end
            for (int p = 0; p < NUM_PADS; p++) begin
                if (word == ((p < 32) ? W_OUT_LO : W_OUT_HI) && wbs_sel_i[(p % 32) / 8]) begin
                    wb_out_d[p] = wbs_dat_i[p % 32];
                end
                if (word == W_PADCFG + 10'(p)) begin
                    if (wbs_sel_i[0]) begin
                        cfg_idx_d[p] = wbs_dat_i[5:0];
                        cfg_en_d[p]  = wbs_dat_i[7];
                    end
                    if (wbs_sel_i[1]) begin
                        cfg_dir_d[p] = wbs_dat_i[8];
                        cfg_src_d[p] = wbs_dat_i[9];
                    end
                end
            end
        end
    end

    // Routing is computed from committed config only, so a rewrite never leaks a half-applied mapping
    always_comb begin
        active    = '0;
        io_out_d  = '0;
        io_oeb_d  = '1;
        fpga_in_d = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            active[p] = route_en_q & cfg_en_q[p] & ({1'b0, cfg_idx_q[p]} < 7'(NUM_FPGA_IO));
            if (active[p] && cfg_dir_q[p]) begin
                io_oeb_d[p] = 1'b0;
                io_out_d[p] = cfg_src_q[p] ? wb_out_q[p] : fpga_out_ext[cfg_idx_q[p]];
            end
        end
        // Descending scan so the lowest-numbered claiming pad is written last and wins
        for (int p = NUM_PADS - 1; p >= 0; p--) begin
            if (active[p] && !cfg_dir_q[p]) begin
                for (int k = 0; k < NUM_FPGA_IO; k++) begin
                    if (cfg_idx_q[p] == 6'(k)) begin
                        fpga_in_d[k] = sync_in[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            route_en_q <= 1'b0;
            wb_out_q   <= '0;
            cfg_en_q   <= '0;
            cfg_dir_q  <= '0;
            cfg_src_q  <= '0;
            io_out_q   <= '0;
            io_oeb_q   <= '1;
            fpga_in_q  <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                cfg_idx_q[p] <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            ack_q      <= req;
            dat_q      <= rd ? rdata : '0;
            route_en_q <= route_en_d;
            wb_out_q   <= wb_out_d;
            cfg_idx_q  <= cfg_idx_d;
            cfg_en_q   <= cfg_en_d;
            cfg_dir_q  <= cfg_dir_d;
            cfg_src_q  <= cfg_src_d;
            io_out_q   <= io_out_d;
            io_oeb_q   <= io_oeb_d;
            fpga_in_q  <= fpga_in_d;
            sync_q[0]  <= io_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = io_out_q;
    assign io_oeb    = io_oeb_q;
    assign fpga_in   = fpga_in_q;
endmodule

// File: tb/tb_fpga_io_router.sv
// tb/tb_fpga_io_router.sv - self-checking bench for fpga_io_router with a read-data scoreboard
module tb_fpga_io_router;
    localparam int          NP   = 38;
    localparam int          NF   = 38;
    localparam logic [31:0] BASE = 32'h3001_0000;
    localparam logic [NP-1:0] ALL = {NP{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   dat_i, adr;
    logic          ack;
    logic [31:0]   dat_o;
    logic [NP-1:0] io_in, io_out, io_oeb;
    logic [NF-1:0] fpga_out, fpga_in;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [31:0]   exp_q[$];
    logic          ack_seen;

    always #5 clk = ~clk;

    fpga_io_router dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .fpga_out  (fpga_out),
        .fpga_in   (fpga_in)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pcfg(input int p);
        return BASE + 32'h100 + 32'(4 * p);
    endfunction

    // Returns at the sample point where ack is high, with stb/cyc already dropped
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdat, output logic acked);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        acked = 1'b0; rdat = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (ack) begin
                acked = 1'b1;
                rdat  = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s = 4'hF);
        logic [31:0] rdat;
        logic        acked;
        wb_xfer(1'b1, a, d, s, rdat, acked);
        if (!acked) check({tag, " ack timeout"}, 64'(acked), 64'd1);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] rdat, ex;
        logic        acked;
        exp_q.push_back(e);
        wb_xfer(1'b0, a, 32'h0, 4'hF, rdat, acked);
        ex = exp_q.pop_front();
        if (!acked) check({tag, " ack timeout"}, 64'(acked), 64'd1);
        else        check(tag, 64'(rdat), 64'(ex));
    endtask

    initial begin
        rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
        io_in = '0; fpga_out = '0;
        tick(2);
        check("rst io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check("rst io_out", 64'(io_out), 64'h0);
        check("rst fpga_in", 64'(fpga_in), 64'h0);
        check("rst ack/dat", {31'b0, ack, dat_o}, 64'h0);
        rst_n = 1'b1;
        tick();

        wb_read("info", BASE + 32'h004, 32'h0202_2626);
        tick();
        check("ack one cycle", 64'(ack), 64'd0);
        check("dat zero after ack", 64'(dat_o), 64'd0);

        stb = 1; cyc = 1; we = 0; adr = 32'h3002_0004; ack_seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); ack_seen |= ack; end
        stb = 0; cyc = 0;
        check("out of window no ack", 64'(ack_seen), 64'd0);

        // Output pad 5 follows fabric bit 5 one cycle late
        wb_write("ctrl", BASE, 32'h1);
        wb_write("pad5", pcfg(5), 32'h185);
        tick();
        check("pad5 oeb", 64'(io_oeb), 64'(ALL & ~(38'd1 << 5)));
        fpga_out = 38'd1 << 5;
        check("pad5 no zero-lat", 64'(io_out), 64'd0);
        tick();
        check("pad5 out hi", 64'(io_out), 64'(38'd1 << 5));
        fpga_out = 38'h3F_FFFF_FFDF;
        tick();
        check("pad5 out lo", 64'(io_out), 64'd0);
        fpga_out = '0;

        // Input pad 30 to fabric 12 with 3-cycle latency
        wb_write("pad30", pcfg(30), 32'h08C);
        io_in[30] = 1'b1;
        tick(2);
        check("pad30 early", 64'(fpga_in), 64'd0);
        tick();
        check("pad30 lat3", 64'(fpga_in), 64'(38'd1 << 12));
        wb_read("pad_in_lo", BASE + 32'h018, 32'h4000_0000);

        // Pads 3 and 9 contend for fabric 7; lowest pad wins
        wb_write("pad3", pcfg(3), 32'h087);
        wb_write("pad9", pcfg(9), 32'h087);
        io_in[9] = 1'b1;
        tick(4);
        check("pad3 wins", 64'(fpga_in), 64'(38'd1 << 12));
        wb_write("pad3 off", pcfg(3), 32'h007);
        tick();
        check("pad9 takes over", 64'(fpga_in), 64'((38'd1 << 12) | (38'd1 << 7)));

        // Firmware-driven pad 37, then global disable
        wb_write("pad37", pcfg(37), 32'h380);
        wb_write("wb_out_hi", BASE + 32'h014, 32'h20);
        tick();
        check("pad37 out", 64'(io_out), 64'(38'd1 << 37));
        check("pad37 oeb", 64'(io_oeb), 64'(ALL & ~((38'd1 << 5) | (38'd1 << 37))));
        wb_read("wb_out_hi rb", BASE + 32'h014, 32'h20);
        wb_write("ctrl off", BASE, 32'h0);
        check("old map holds", 64'(io_oeb), 64'(ALL & ~((38'd1 << 5) | (38'd1 << 37))));
        tick();
        check("route off oeb", 64'(io_oeb), 64'(ALL));
        check("route off out", 64'(io_out), 64'd0);
        check("route off fpga_in", 64'(fpga_in), 64'd0);

        // idx beyond fabric width keeps pad disabled
        wb_write("pad37 idx40", pcfg(37), 32'h1A8);
        wb_write("ctrl on", BASE, 32'h1);
        fpga_out = '1;
        tick();
        check("idx40 oeb", 64'(io_oeb), 64'(ALL & ~(38'd1 << 5)));
        check("idx40 out", 64'(io_out), 64'(38'd1 << 5));
        check("route on fpga_in", 64'(fpga_in), 64'((38'd1 << 12) | (38'd1 << 7)));

        wb_write("pad0 byte", pcfg(0), 32'hFFFF_FF85, 4'b0001);
        wb_read("pad0 rb", pcfg(0), 32'h85);
        wb_read("pad5 rb", pcfg(5), 32'h185);
        wb_read("unmapped", BASE + 32'h008, 32'h0);
        wb_read("pad38 raz", pcfg(38), 32'h0);
        wb_read("ctrl rb", BASE, 32'h1);

        // Reset in the middle of an access
        stb = 1; cyc = 1; we = 1; adr = BASE; dat_i = 32'h0; sel = 4'hF;
        #3 rst_n = 1'b0;
        #1;
        check("midrst oeb", 64'(io_oeb), 64'(ALL));
        check("midrst out", 64'(io_out), 64'd0);
        check("midrst fpga_in", 64'(fpga_in), 64'd0);
        tick();
        check("midrst no ack", 64'(ack), 64'd0);
        stb = 0; cyc = 0; we = 0;
        rst_n = 1'b1;
        tick();
        wb_read("ctrl after rst", BASE, 32'h0);
        wb_read("pad5 after rst", pcfg(5), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fpga_io_router.md
Name: fpga_io_router

Overview:
- Programmable pad router between the Caravel user IO pads and the FPGA fabric's flat GPIO bus.
- Replaces fixed, hand-wired pad assignment. Each pad's fabric index, direction and drive source are set at runtime over Wishbone.
- Sits in the user wrapper beside the fabric's Wishbone configuration port, on its own address window.
- Also gives firmware direct pad drive and synchronized pad readback, for bring-up without a bitstream.

Parameters:
- NUM_PADS, 38, number of user IO pads routed (1..64).
- NUM_FPGA_IO, 38, width of the fabric GPIO bus, north+south+east+west (1..64).
- BASE_ADDR, 32'h3001_0000, Wishbone window base; window is 4 KiB, decode on wbs_adr_i[31:12].
- SYNC_STAGES, 2, synchronizer depth on the pad input path (>=2).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  NUM_PADS  pad inputs.
- io_out  out  NUM_PADS  pad outputs.
- io_oeb  out  NUM_PADS  pad output-enable bar (1 = input).
- fpga_out  in  NUM_FPGA_IO  fabric outputs toward pads.
- fpga_in  out  NUM_FPGA_IO  fabric inputs from pads.

Behaviour:
- Reset (async assert, sync release):
  - all config, CTRL and WB_OUT registers 0.
  - wbs_ack_o=0, wbs_dat_o=0.
  - io_out all 0, io_oeb all 1.
  - fpga_in all 0; synchronizer flops 0.
- Register map (offset from BASE_ADDR):
  - 0x000 CTRL: bit0 route_en; other bits RAZ/WI.
  - 0x004 INFO (RO): [7:0] NUM_PADS, [15:8] NUM_FPGA_IO, [23:16] SYNC_STAGES, [31:24] 8'h02.
  - 0x010 / 0x014 WB_OUT_LO / WB_OUT_HI: firmware drive value for pads 0-31 / 32-63.
  - 0x018 / 0x01C PAD_IN_LO / PAD_IN_HI (RO): synchronized io_in.
  - 0x100 + 4*p PADCFG[p], p < NUM_PADS:
    - [5:0] idx.
    - bit7 en.
    - bit8 dir (1 = pad output).
    - bit9 src (1 = drive from WB_OUT[p], 0 = from fpga_out[idx]).
  - Bits beyond NUM_PADS and unlisted bits are RAZ/WI.
- Wishbone handshake:
  - A request is stb&cyc&window_hit&~wbs_ack_o, sampled on a rising edge.
  - wbs_ack_o goes high for exactly one cycle on the following edge; one wait-free access every 2 cycles.
  - Write data is committed on that same edge, per byte lane under wbs_sel_i.
  - wbs_dat_o is registered, valid while ack is high, 0 otherwise.
  - Unmapped offsets inside the window: acked, read 0, writes dropped.
  - Addresses outside the window: no ack.
  - Dropping stb or cyc before ack cancels nothing already sampled.
- Output routing (registered, updates on the edge after the config commit):
  - A pad is active if route_en & en & (idx < NUM_FPGA_IO).
  - Active and dir=1: io_oeb[p]=0; io_out[p] = src ? WB_OUT[p] : fpga_out[idx].
  - All other cases: io_oeb[p]=1, io_out[p]=0.
  - fpga_out-to-io_out latency: 1 cycle.
- Input routing:
  - io_in passes through SYNC_STAGES flops, giving sync_in.
  - fpga_in[k] = sync_in[p] for the lowest-numbered active pad p with dir=0 and idx=k; 0 if no such pad.
  - fpga_in is registered; io_in-to-fpga_in latency is SYNC_STAGES+1 cycles.
  - PAD_IN reads sync_in regardless of route_en.
- Two pads with dir=1 on the same idx: both drive (fan-out is legal).
- Reset asserted mid-transaction: ack is suppressed and the transaction is lost.
- Config rewrite while traffic flows: the old mapping holds until the commit edge; no glitch cycle with oeb=0 on a pad that is being disabled.

Test Plan:
- Reset, then read 0x004 -> 32'h0202_2626 with defaults; io_oeb = 38'h3F_FFFF_FFFF; fpga_in = 0; ack pulses exactly 1 cycle.
- Write CTRL=1, PADCFG[5]=0x185 (en, dir out, idx 5), fpga_out[5] toggling -> io_oeb[5]=0 and io_out[5] follows fpga_out[5] with 1-cycle lag; other pads unaffected.
- PADCFG[30]=0x080|12 (input, idx 12), drive io_in[30]=1 -> fpga_in[12]=1 after exactly 3 cycles; PAD_IN_LO bit30 reads 1.
- PADCFG[3] and PADCFG[9] both input on idx 7, io_in[3]=0, io_in[9]=1 -> fpga_in[7]=0 (pad 3 wins); disable pad 3 -> fpga_in[7]=1.
- PADCFG[37]=0x380 (src=WB), write WB_OUT_HI=0x20 -> io_out[37]=1; clear CTRL.route_en -> io_oeb[37]=1, io_out[37]=0 next cycle; idx=40 with NUM_FPGA_IO=38 -> pad stays disabled.
- Byte-lane write with sel=4'b0001 of 0xFFFF_FF85 to PADCFG[0] -> reads back 0x85; assert wb_rst_ni mid-access -> no ack, all outputs at reset values immediately.
